ctrl_word_sequencer: RTL and testbench

CTRL_WORD_SEQUENCER -- requirements
Module: ctrl_word_sequencer

---
 rtl/ctrl_word_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ctrl_word_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_word_sequencer.sv
// Control-word sequencer: plays a programmed table of control words onto the
// datapath, one per cycle, with stall/stop, one-shot or looped playback.
module ctrl_word_sequencer #(
    parameter int CW_W  = 23,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [CW_W-1:0] load_data,
    input  logic            start,
    input  logic [AW:0]     length,
    input  logic            loop_mode,
    input  logic            stall,
    input  logic            stop,
    output logic [CW_W-1:0] cw_out,
    output logic            cw_valid,
    output logic [AW-1:0]   step_idx,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      pass_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW_W-1:0] r_mem [DEPTH];

    logic [CW_W-1:0] r_cw;
    logic            r_valid;
    logic [AW-1:0]   r_step;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [7:0]      r_pass;
    logic [AW-1:0]   r_last;
    logic            r_loop;

    logic [CW_W-1:0] w_cw_nxt;
    logic            w_valid_nxt;
    logic [AW-1:0]   w_step_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic [7:0]      w_pass_nxt;
    logic [AW-1:0]   w_last_nxt;
    logic            w_loop_nxt;

    logic            w_wr;
    logic            w_len_ok;
    logic [CW_W-1:0] w_word0;
    logic [AW-1:0]   w_step_inc;

    assign w_wr       = load_en && (r_state != RUN);
    assign w_len_ok   = (length != '0) && (length <= (AW+1)'(DEPTH));
    assign w_step_inc = r_step + AW'(1);
    // A write to slot 0 in the start cycle is forwarded so the first word is current.
    assign w_word0    = (w_wr && (load_addr == '0)) ? load_data : r_mem[0];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cw_nxt    = r_cw;
        w_valid_nxt = r_valid;
        w_step_nxt  = r_step;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_pass_nxt  = r_pass;
        w_last_nxt  = r_last;
        w_loop_nxt  = r_loop;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_state_nxt = RUN;
                        w_cw_nxt    = w_word0;
                        w_valid_nxt = 1'b1;
                        w_step_nxt  = '0;
                        w_busy_nxt  = 1'b1;
                        w_pass_nxt  = '0;
                        w_last_nxt  = length[AW-1:0] - AW'(1);
                        w_loop_nxt  = loop_mode;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_cw_nxt    = '0;
                    w_valid_nxt = 1'b0;
                    w_step_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                end else if (!stall) begin
                    if (r_step != r_last) begin
                        w_step_nxt = w_step_inc;
                        w_cw_nxt   = r_mem[w_step_inc];
                    end else if (r_loop) begin
                        w_step_nxt = '0;
                        w_cw_nxt   = r_mem[0];
                        w_pass_nxt = (r_pass != 8'hFF) ? r_pass + 8'd1 : r_pass;
                    end else begin
                        w_state_nxt = FIN;
                        w_cw_nxt    = '0;
                        w_valid_nxt = 1'b0;
                        w_step_nxt  = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cw    <= '0;
            r_valid <= 1'b0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_pass  <= '0;
            r_last  <= '0;
            r_loop  <= 1'b0;
        end else begin
            r_cw    <= w_cw_nxt;
            r_valid <= w_valid_nxt;
            r_step  <= w_step_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_pass  <= w_pass_nxt;
            r_last  <= w_last_nxt;
            r_loop  <= w_loop_nxt;
        end
    end

    assign cw_out   = r_cw;
    assign cw_valid = r_valid;
    assign step_idx = r_step;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign pass_cnt = r_pass;

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Bench for ctrl_word_sequencer: directed scenarios plus random traffic, all
// cycles checked against a queue-based playback model.
module tb_ctrl_word_sequencer;

    localparam int CW_W  = 23;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [CW_W-1:0] load_data;
    logic            start;
    logic [AW:0]     length;
    logic            loop_mode;
    logic            stall;
    logic            stop;
    logic [CW_W-1:0] cw_out;
    logic            cw_valid;
    logic [AW-1:0]   step_idx;
    logic            busy;
    logic            done;
    logic            err;
    logic [7:0]      pass_cnt;

    int n_total = 0;
    int n_bad   = 0;

    ctrl_word_sequencer #(
        .CW_W (CW_W),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .start    (start),
        .length   (length),
        .loop_mode(loop_mode),
        .stall    (stall),
        .stop     (stop),
        .cw_out   (cw_out),
        .cw_valid (cw_valid),
        .step_idx (step_idx),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .pass_cnt (pass_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 playing, 2 finishing; m_q holds the
    // slots still to be shown in this pass, front = slot on the output.
    logic [CW_W-1:0] m_mem [DEPTH];
    int              m_phase;
    int              m_q[$];
    int              m_len;
    bit              m_loop;
    int              m_pass;

    logic [CW_W-1:0] e_cw;
    logic            e_valid;
    int              e_step;
    logic            e_busy;
    logic            e_done;
    logic            e_err;
    int              e_pass;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_outputs();
        e_valid = (m_phase == 1);
        e_busy  = (m_phase == 1);
        e_cw    = (m_phase == 1) ? m_mem[m_q[0]] : '0;
        e_step  = (m_phase == 1) ? m_q[0] : 0;
        e_pass  = m_pass;
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_q.delete();
        m_pass  = 0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        model_outputs();
    endfunction

    function automatic void model_edge();
        int prev;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        prev = m_phase;
        if (load_en && prev != 1) m_mem[load_addr] = load_data;
        case (prev)
            0: if (start) begin
                if (int'(length) >= 1 && int'(length) <= DEPTH) begin
                    m_phase = 1;
                    m_len   = int'(length);
                    m_loop  = loop_mode;
                    m_pass  = 0;
                    m_q.delete();
                    for (int i = 0; i < m_len; i++) m_q.push_back(i);
                end else begin
                    e_err = 1'b1;
                end
            end
            1: if (stop) begin
                m_phase = 0;
                m_q.delete();
            end else if (!stall) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    if (m_loop) begin
                        for (int i = 0; i < m_len; i++) m_q.push_back(i);
                        if (m_pass < 255) m_pass++;
                    end else begin
                        m_phase = 2;
                        e_done  = 1'b1;
                    end
                end
            end
            default: m_phase = 0;
        endcase
        model_outputs();
    endfunction

    task automatic compare_all();
        check_val("cw_out",   32'(cw_out),   32'(e_cw));
        check_val("cw_valid", 32'(cw_valid), 32'(e_valid));
        check_val("step_idx", 32'(step_idx), 32'(e_step));
        check_val("busy",     32'(busy),     32'(e_busy));
        check_val("done",     32'(done),     32'(e_done));
        check_val("err",      32'(err),      32'(e_err));
        check_val("pass_cnt", 32'(pass_cnt), 32'(e_pass));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        length    = '0;
        loop_mode = 1'b0;
        stall     = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic load(input int addr, input logic [CW_W-1:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic go(input int len, input bit lp);
        start     = 1'b1;
        length    = (AW+1)'(len);
        loop_mode = lp;
        tick();
        start     = 1'b0;
    endtask

    // Reset raised between edges: outputs must clear before the next edge.
    task automatic async_reset();
        load_en = 1'b0;
        start   = 1'b0;
        #2 rst  = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_val("async_rst_cw",   32'(cw_out), 32'h0);
        check_val("async_rst_busy", 32'(busy),   32'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) load(i, CW_W'($urandom));

        // one-shot playback of four one-hot words
        load(0, 23'h000001);
        load(1, 23'h000002);
        load(2, 23'h000004);
        load(3, 23'h000008);
        go(4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check_val("oneshot_word", 32'(cw_out), 32'(1) << k);
            tick();
        end
        check_val("oneshot_done", 32'(done), 32'h1);
        tick();
        check_val("oneshot_idle", 32'(busy), 32'h0);
        tick();

        // stall while slot 1 is on the output
        go(4, 1'b0);
        tick();
        stall = 1'b1;
        repeat (3) tick();
        check_val("stall_hold", 32'(cw_out), 32'h2);
        stall = 1'b0;
        tick();
        check_val("stall_resume", 32'(cw_out), 32'h4);
        tick();
        tick();
        check_val("stall_done", 32'(done), 32'h1);
        tick();

        // looped playback then stop
        go(2, 1'b1);
        repeat (9) tick();
        check_val("loop_pass4", 32'(pass_cnt), 32'h4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("stop_cw", 32'(cw_out), 32'h0);
        check_val("stop_busy", 32'(busy), 32'h0);
        repeat (2) tick();

        // illegal lengths and writes attempted during playback
        go(0, 1'b0);
        check_val("err_len0", 32'(err), 32'h1);
        tick();
        go(17, 1'b0);
        check_val("err_len17", 32'(err), 32'h1);
        check_val("err_len17_busy", 32'(busy), 32'h0);
        tick();
        go(2, 1'b0);
        load(0, 23'h555555);
        repeat (3) tick();
        go(1, 1'b0);
        check_val("run_write_ignored", 32'(cw_out), 32'h1);
        repeat (2) tick();

        // asynchronous reset mid-playback, memory survives
        go(4, 1'b0);
        tick();
        tick();
        check_val("pre_rst_step", 32'(step_idx), 32'h2);
        async_reset();
        tick();
        go(4, 1'b0);
        check_val("post_rst_word0", 32'(cw_out), 32'h1);
        repeat (6) tick();

        // write and start in the same cycle, single-slot program
        load_en   = 1'b1;
        load_addr = '0;
        load_data = 23'h7FFFFF;
        go(1, 1'b0);
        load_en   = 1'b0;
        check_val("wr_start_word", 32'(cw_out), 32'h7FFFFF);
        tick();
        check_val("wr_start_done", 32'(done), 32'h1);
        tick();

        // pass counter saturation
        go(1, 1'b1);
        repeat (260) tick();
        check_val("pass_sat", 32'(pass_cnt), 32'hFF);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        for (int c = 0; c < 3000; c++) begin
            load_en   = ($urandom_range(0, 99) < 30);
            load_addr = AW'($urandom);
            load_data = CW_W'($urandom);
            start     = ($urandom_range(0, 99) < 12);
            length    = (AW+1)'($urandom_range(0, 17));
            loop_mode = $urandom_range(0, 1) != 0;
            stall     = ($urandom_range(0, 99) < 20);
            stop      = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 199) == 0) async_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
